// File: rtl/msg_block_packer_pkg.sv
// Shared constants and state encoding for the plaintext block packer.
package msg_block_packer_pkg;
    localparam int N_B       = 64;
    localparam int BLK_BYTES = N_B / 8;
    localparam int PAD_W     = 8;
    localparam logic [N_B-1:0] PAD_BLOCK = {BLK_BYTES{8'h08}};

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_PADBLK = 2'd2
    } state_t;
endpackage

// File: rtl/msg_pad_fill.sv
// PKCS#7 fill of a final partial block; combinational, no backpressure.
// Bytes after index cnt are overwritten with 7-cnt (8 minus message bytes).
module msg_pad_fill
    import msg_block_packer_pkg::*;
(
    input  logic [N_B-1:0] blk,
    input  logic [2:0]     cnt,
    output logic [N_B-1:0] padded
);
    logic [PAD_W-1:0] pad_val;

    always_comb begin
        pad_val = {5'd0, 3'd7 - cnt};
        padded  = blk;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if (i > int'(cnt)) begin
                padded[N_B-1-8*i -: 8] = pad_val;
            end
        end
    end
endmodule

// File: rtl/msg_block_packer.sv
// Byte stream to 64-bit block packer; a block is valid the cycle after its closing byte, refill resumes the cycle after hand-off.
// s_ready is low while a block waits for m_ready; MSG_PAD_EN selects PKCS#7 padding.
module msg_block_packer
    import msg_block_packer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     s_data,
    input  logic           s_valid,
    input  logic           s_last,
    output logic           s_ready,
    output logic [N_B-1:0] m_block,
    output logic [3:0]     m_bytes,
    output logic           m_last,
    output logic           m_valid,
    input  logic           m_ready
);
    state_t         state;
    logic [2:0]     cnt;
    logic [N_B-1:0] blk;
    logic [N_B-1:0] merged;
    logic [N_B-1:0] closed;
    logic [5:0]     bit_hi;
    logic [3:0]     bytes_r;
    logic           last_r;
    logic           pad_pending;

    assign bit_hi = 6'd63 - {cnt, 3'b000};

    always_comb begin
        merged = blk;
        merged[bit_hi -: 8] = s_data;
    end

`ifdef MSG_PAD_EN
    localparam bit PAD_EN = 1'b1;
    // A block closed by cnt=7 has no free bytes, so the filler is a no-op there.
    msg_pad_fill u_pad_fill (
        .blk    (merged),
        .cnt    (cnt),
        .padded (closed)
    );
`else
    localparam bit PAD_EN = 1'b0;
    assign closed = merged;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FILL;
            cnt         <= 3'd0;
            blk         <= '0;
            bytes_r     <= 4'd0;
            last_r      <= 1'b0;
            pad_pending <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (s_valid) begin
                        if (cnt == 3'd7 || s_last) begin
                            state       <= ST_HOLD;
                            blk         <= closed;
                            bytes_r     <= {1'b0, cnt} + 4'd1;
                            last_r      <= s_last && !(PAD_EN && cnt == 3'd7);
                            pad_pending <= PAD_EN && s_last && cnt == 3'd7;
                        end else begin
                            cnt <= cnt + 3'd1;
                            blk <= merged;
                        end
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        if (pad_pending) begin
                            state       <= ST_PADBLK;
                            blk         <= PAD_BLOCK;
                            bytes_r     <= 4'd0;
                            last_r      <= 1'b1;
                            pad_pending <= 1'b0;
                        end else begin
                            state   <= ST_FILL;
                            cnt     <= 3'd0;
                            blk     <= '0;
                            bytes_r <= 4'd0;
                            last_r  <= 1'b0;
                        end
                    end
                end
                ST_PADBLK: begin
                    if (m_ready) begin
                        state   <= ST_FILL;
                        cnt     <= 3'd0;
                        blk     <= '0;
                        bytes_r <= 4'd0;
                        last_r  <= 1'b0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    assign s_ready = (state == ST_FILL);
    assign m_valid = (state != ST_FILL);
    assign m_block = blk;
    assign m_bytes = bytes_r;
    assign m_last  = last_r;
endmodule

// File: tb/tb_msg_block_packer.sv
// Randomized bench for msg_block_packer against a message-level block model.
module tb_msg_block_packer;
`ifdef MSG_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    typedef struct {
        logic [63:0] blk;
        logic [3:0]  bytes;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [63:0] m_block;
    logic [3:0]  m_bytes;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;

    msg_block_packer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_block (m_block),
        .m_bytes (m_bytes),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [7:0]  msg_q[$];
    logic [9:0]  in_q[$];     // {closes_block, last, data}
    exp_t        exp_q[$];
    int          xfer_cyc[$];
    logic        vld_model = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Turns msg_q into the byte items to drive and the blocks the encryptor should see.
    task automatic push_msg();
        int len;
        len = msg_q.size();
        for (int i = 0; i < len; i++)
            in_q.push_back({(i % 8 == 7) || (i == len - 1), i == len - 1, msg_q[i]});
        for (int b = 0; b < len; b += 8) begin
            int   n;
            bit   fin;
            exp_t e;
            n   = (len - b < 8) ? len - b : 8;
            fin = (b + 8 >= len);
            e.blk = '0;
            for (int i = 0; i < 8; i++) begin
                if (i < n)
                    e.blk[63-8*i -: 8] = msg_q[b+i];
                else if (fin && PAD)
                    e.blk[63-8*i -: 8] = 8'(8 - n);
            end
            e.bytes = 4'(n);
            e.last  = fin && !(PAD && n == 8);
            exp_q.push_back(e);
            if (fin && PAD && n == 8) begin
                e.blk   = {8{8'h08}};
                e.bytes = 4'd0;
                e.last  = 1'b1;
                exp_q.push_back(e);
            end
        end
        msg_q.delete();
    endtask

    task automatic cycle(input int pv, input int pr);
        logic [9:0] it;
        exp_t       h;
        logic       acc;
        logic       xfer;
        @(negedge clk);
        cyc++;
        m_ready = ($urandom_range(0, 99) < pr);
        if (s_ready && in_q.size() > 0 && $urandom_range(0, 99) < pv) begin
            it      = in_q[0];
            s_valid = 1'b1;
            s_data  = it[7:0];
            s_last  = it[8];
        end else begin
            s_valid = !s_ready;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
        end
        chk("m_valid", m_valid, vld_model);
        chk("s_ready", s_ready, !vld_model);
        if (m_valid) begin
            chk("blk_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                chk("m_block", m_block, exp_q[0].blk);
                chk("m_bytes", m_bytes, exp_q[0].bytes);
                chk("m_last", m_last, exp_q[0].last);
            end
        end
        acc  = s_valid && s_ready;
        xfer = m_valid && m_ready;
        if (acc && in_q.size() > 0) begin
            it        = in_q.pop_front();
            vld_model = it[9];
        end
        if (xfer && exp_q.size() > 0) begin
            h = exp_q.pop_front();
            xfer_cyc.push_back(cyc);
            vld_model = exp_q.size() > 0 && exp_q[0].bytes == 4'd0;
        end
    endtask

    task automatic drain(input int pv, input int pr);
        int k;
        k = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && k < 3000) begin
            cycle(pv, pr);
            k++;
        end
        chk("drain_done", 64'(in_q.size() + exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_m_block"}, m_block, 0);
        chk({tag, "_m_bytes"}, m_bytes, 0);
        chk({tag, "_m_last"}, m_last, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int d0;
        int d1;
        int k;
        rst_n   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Full block ending exactly on the boundary
        for (int i = 1; i <= 8; i++) msg_q.push_back(8'(i));
        push_msg();
        drain(100, 100);

        // Partial final block
        msg_q = '{8'hDE, 8'hAD, 8'hBE};
        push_msg();
        drain(100, 100);

        // One-byte message
        msg_q.push_back(8'h41);
        push_msg();
        drain(80, 70);

        // Reset with three bytes of a block already loaded
        for (int i = 0; i < 6; i++) msg_q.push_back(8'(8'h30 + i));
        push_msg();
        k = 0;
        while (in_q.size() > 3 && k < 20) begin
            cycle(100, 0);
            k++;
        end
        chk("preload_bytes", 64'(in_q.size()), 3);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_reset_outputs("midrst");
        in_q.delete();
        exp_q.delete();
        vld_model = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Message after reset: earlier partial bytes must not appear
        msg_q.push_back(8'hAA);
        push_msg();
        drain(100, 100);

        // Backpressure: block waits while junk is driven on the byte side
        msg_q = '{8'h11, 8'h22, 8'h33};
        push_msg();
        repeat (9) cycle(100, 0);
        drain(100, 100);

        // Throughput and ordering with both sides always ready
        for (int i = 0; i < 16; i++) msg_q.push_back(8'(i));
        push_msg();
        xfer_cyc.delete();
        c0 = cyc + 1;
        drain(100, 100);
        d0 = (xfer_cyc.size() >= 2) ? xfer_cyc[0] - c0 : -1;
        d1 = (xfer_cyc.size() >= 2) ? xfer_cyc[1] - xfer_cyc[0] : -1;
        chk("first_blk_latency", 64'(d0), 8);
        chk("blk_spacing", 64'(d1), 9);

        // Random messages with random stalls on both sides
        for (int b = 0; b < 8; b++) begin
            for (int m = 0; m < 5; m++) begin
                int len;
                len = $urandom_range(1, 20);
                for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
                push_msg();
            end
            drain($urandom_range(40, 100), $urandom_range(30, 100));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
